// File: rtl/connector_pkg.sv
// Shared types for the CVA6 trace-encoder connector: committed-op and control-flow
// encodings, E-Trace itype codes and the resolved-branch FIFO entry.
package connector_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [7:0] {
    ADD, SUB, ANDL, ORL, XORL, SLL, SRL, LD, SD,
    EQ, NE, LTS, GES, LTU, GEU,
    JALR, MRET, SRET, DRET, ECALL, WFI, FENCE
  } fu_op;

  typedef enum logic [2:0] {NoCF, Branch, Jump, JumpR, Return} cf_t;

  typedef enum logic [3:0] {
    IT_STANDARD      = 4'd0,
    IT_EXCEPTION     = 4'd1,
    IT_INTERRUPT     = 4'd2,
    IT_ERET          = 4'd3,
    IT_BR_NOT_TAKEN  = 4'd4,
    IT_BR_TAKEN      = 4'd5,
    IT_UNINF_JUMP_L3 = 4'd6,
    IT_RESERVED      = 4'd7,
    IT_UNINF_CALL    = 4'd8,
    IT_INF_CALL      = 4'd9,
    IT_UNINF_JUMP    = 4'd10,
    IT_INF_JUMP      = 4'd11
  } itype_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
  } br_entry_t;

  function automatic logic is_cond_branch(fu_op op);
    return op inside {EQ, NE, LTS, GES, LTU, GEU};
  endfunction

  function automatic logic is_eret_op(fu_op op);
    return op inside {MRET, SRET, DRET};
  endfunction

  // x1 (ra) and x5 (t0) are the ABI link registers.
  function automatic logic is_link_reg(logic [4:0] rd);
    return (rd == 5'd1) || (rd == 5'd5);
  endfunction

endpackage

// File: rtl/branch_outcome_fifo.sv
// Resolved-branch outcome FIFO: one push and up to NRET pops per cycle, with a
// window of the NRET oldest entries exposed for in-order matching.
module branch_outcome_fifo
  import connector_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned NRET  = 2,
  localparam int unsigned CW    = $clog2(DEPTH) + 1,
  localparam int unsigned PW    = $clog2(NRET + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  br_entry_t             push_entry_i,
  input  logic [PW-1:0]         pop_cnt_i,
  output br_entry_t [NRET-1:0]  head_o,
  output logic [CW-1:0]         count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  br_entry_t     mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, count_after_pop;
  logic          push_ok;

  // Pops are retired before the push is judged, so a full FIFO that pops accepts.
  always_comb begin
    count_after_pop = count_q - CW'(pop_cnt_i);
    push_ok         = push_i && (count_after_pop < CW'(DEPTH));
    drop_o          = push_i && !push_ok;
    count_d         = count_after_pop + CW'(push_ok);
    rd_ptr_d        = rd_ptr_q + AW'(pop_cnt_i);
    wr_ptr_d        = wr_ptr_q + AW'(push_ok);
  end

  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      head_o[i] = mem_q[AW'(rd_ptr_q + AW'(i))];
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the payload array is not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/itype_detector_mr.sv
// Multi-retire E-Trace itype classifier with an internal resolved-branch FIFO.
// Define CONNECTOR_CALL_DETECT_EN to emit call codes 8/9 when ITYPE_LEN is 4.
module itype_detector_mr
  import connector_pkg::*;
#(
  parameter int unsigned NRET      = 2,
  parameter int unsigned BR_DEPTH  = 8,
  parameter int unsigned ITYPE_LEN = 3
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NRET-1:0]                     valid_i,
  input  fu_op [NRET-1:0]                     op_i,
  input  cf_t  [NRET-1:0]                     cf_type_i,
  input  logic [NRET-1:0][XLEN-1:0]           pc_i,
  input  logic [NRET-1:0][4:0]                rd_i,
  input  logic                                exception_i,
  input  logic                                interrupt_i,
  input  logic                                resolve_valid_i,
  input  logic [XLEN-1:0]                     resolve_pc_i,
  input  logic                                resolve_taken_i,
  output logic [NRET-1:0][ITYPE_LEN-1:0]      itype_o,
  output logic [NRET-1:0]                     valid_o,
  output logic                                br_empty_o,
  output logic                                br_full_o,
  output logic                                overflow_o,
  output logic                                mismatch_o
);

  localparam int unsigned PW   = $clog2(NRET + 1);
  localparam int unsigned CW   = $clog2(BR_DEPTH) + 1;
  localparam bit          Len4 = (ITYPE_LEN == 4);
`ifdef CONNECTOR_CALL_DETECT_EN
  localparam bit CallDetect = Len4;
`else
  localparam bit CallDetect = 1'b0;
`endif

  br_entry_t [NRET-1:0]          head;
  logic [CW-1:0]                 br_count;
  logic [PW-1:0]                 pop_cnt;
  logic                          br_drop;
  logic [NRET-1:0][3:0]          code;
  logic [NRET-1:0][ITYPE_LEN-1:0] itype_d, itype_q;
  logic [NRET-1:0]               valid_d, valid_q;
  logic                          mismatch_d, mismatch_q, overflow_q;
  logic                          trap;

  assign trap = exception_i | interrupt_i;

  branch_outcome_fifo #(
    .DEPTH (BR_DEPTH),
    .NRET  (NRET)
  ) u_br_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (resolve_valid_i),
    .push_entry_i ('{pc: resolve_pc_i, taken: resolve_taken_i}),
    .pop_cnt_i    (pop_cnt),
    .head_o       (head),
    .count_o      (br_count),
    .full_o       (br_full_o),
    .empty_o      (br_empty_o),
    .drop_o       (br_drop)
  );

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    int        pops;
    logic      chain_ok;
    logic      call;
    br_entry_t hd;
    pops       = 0;
    chain_ok   = 1'b1;
    mismatch_d = 1'b0;
    for (int k = 0; k < NRET; k++) begin
      code[k]    = IT_STANDARD;
      valid_d[k] = valid_i[k];
      call       = CallDetect && is_link_reg(rd_i[k]);
      hd         = head[0];
      for (int j = 1; j < NRET; j++) begin
        if (j == pops) hd = head[j];
      end
      if (k == 0 && exception_i) begin
        code[k] = IT_EXCEPTION;
      end else if (k == 0 && interrupt_i) begin
        code[k] = IT_INTERRUPT;
      end else if (trap) begin
        valid_d[k] = 1'b0;
      end else if (valid_i[k]) begin
        if (is_eret_op(op_i[k]) && cf_type_i[k] == Return) begin
          code[k] = IT_ERET;
        end else if (is_cond_branch(op_i[k])) begin
          // Branches match FIFO entries strictly in order; the first miss ends the chain.
          if (chain_ok && pops < int'(br_count) && hd.pc == pc_i[k]) begin
            code[k] = hd.taken ? IT_BR_TAKEN : IT_BR_NOT_TAKEN;
            pops    = pops + 1;
          end else begin
            chain_ok   = 1'b0;
            mismatch_d = 1'b1;
          end
        end else if (op_i[k] == JALR || cf_type_i[k] == JumpR) begin
          if (Len4) code[k] = call ? IT_UNINF_CALL : IT_UNINF_JUMP;
          else      code[k] = IT_UNINF_JUMP_L3;
        end else if (cf_type_i[k] == Jump) begin
          if (Len4) code[k] = call ? IT_INF_CALL : IT_INF_JUMP;
        end
      end
      itype_d[k] = code[k][ITYPE_LEN-1:0];
    end
    pop_cnt = PW'(pops);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      itype_q    <= '0;
      valid_q    <= '0;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      itype_q    <= itype_d;
      valid_q    <= valid_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_q | br_drop;
    end
  end

  assign itype_o    = itype_q;
  assign valid_o    = valid_q;
  assign mismatch_o = mismatch_q;
  assign overflow_o = overflow_q;

endmodule
